bp_update_sched: RTL
====================

Name: bp_update_sched

Overview:
- Single-write-port scheduler for the four branch-predictor tables: base, and the tagged tables T1, T2 and T3 (4-, 8- and 14-bit history).
- Sits between the EX-stage resolve logic and the table arrays.
- Buffers resolved-branch update requests in a small FIFO and drains them as per-table write strobes.
- Decides allocation into the next-longer-history table on a mispredict, and sequences a multi-cycle zeroing sweep after reset or a clear request.

Parameters:
- IDX_W, 11, table index width; each table has 2**IDX_W entries.
- DEPTH, 4, update FIFO depth; power of two, at least 2.
- CNT_W, 16, width of the saturating allocation counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_upd_valid  in  1  resolved branch/jump update request from EX
- o_upd_ready  out  1  request accepted when i_upd_valid and o_upd_ready are both high
- i_upd_idx  in  4*IDX_W  per-table index; table k at [k*IDX_W +: IDX_W]; k=0 base, 1..3 = T1..T3
- i_upd_prov  in  2  provider table that made the prediction (0..3)
- i_upd_taken  in  1  resolved direction
- i_upd_mispred  in  1  prediction was wrong
- i_clear  in  1  single-cycle request to wipe all tables
- o_wr_en  out  4  per-table write strobe
- o_wr_idx  out  4*IDX_W  per-table write index
- o_wr_zero  out  1  write zero to the whole entry (sweep)
- o_wr_alloc  out  4  table is being freshly allocated (tag install, weak counter)
- o_wr_taken  out  1  direction used for counter update or allocation
- o_init_done  out  1  tables valid; predictions may be used
- o_alloc_cnt  out  CNT_W  saturating count of allocations

Behaviour:
- Reset is asynchronous, active-low, clock i_clk.
- Reset values: state=INIT, sweep counter 0, FIFO empty, all outputs 0 except o_upd_ready=1 (FIFO not full), o_alloc_cnt=0.
- State INIT:
  - Each cycle: o_wr_en=4'hF, o_wr_zero=1, all four idx fields = sweep counter, o_wr_alloc=0.
  - The counter increments from 0 to 2**IDX_W-1, so the sweep takes exactly 2**IDX_W cycles.
  - The cycle after the last write, state=RUN and o_init_done=1.
  - The FIFO accepts requests during INIT but does not drain them.
- State RUN: each cycle with the FIFO non-empty, pop the head and drive the writes combinationally from the head entry.
  - Provider table p=prov: o_wr_en[p]=1, o_wr_taken=taken, o_wr_alloc[p]=0.
  - If mispred and p<3: additionally o_wr_en[p+1]=1 and o_wr_alloc[p+1]=1. o_alloc_cnt increments and saturates at all-ones.
  - If mispred and p==3: no allocation.
  - o_wr_idx carries all four head indices regardless of the enables.
  - FIFO empty: o_wr_en=0.
- State CLEAR:
  - Entered from RUN when i_clear=1. The FIFO is flushed in the same edge; a request accepted in that cycle is dropped.
  - o_init_done deasserts on the next cycle.
  - Sweep behaviour is identical to INIT, then return to RUN.
  - i_clear during INIT/CLEAR restarts the sweep at 0.
- Handshake:
  - o_upd_ready = !full (registered count; not pop-aware).
  - Latency: a request accepted at edge N is written no earlier than cycle N+1.
  - Data, idx and flags are captured at acceptance; later input changes have no effect.
- Boundary cases:
  - Full FIFO with a pop: ready stays 0 that cycle.
  - Push and pop in the same cycle while not full: count unchanged, ordering preserved.
  - Pointers wrap modulo DEPTH.
- Reset mid-sweep or mid-drain: immediate return to the reset values; a new full sweep follows.
- Widths: o_alloc_cnt is unsigned and saturates with no wrap.

Test Plan:
- IDX_W=3, DEPTH=4: release reset -> 8 cycles of o_wr_en=4'hF, o_wr_zero=1, idx 0..7; o_init_done=1 on cycle 9; o_wr_en=0 after.
- After init, push prov=1, taken=1, mispred=1, idx={3'd7,3'd5,3'd2,3'd1} -> next cycle o_wr_en=4'b0110, o_wr_alloc=4'b0100, o_wr_idx equals input, o_wr_taken=1, o_alloc_cnt=1.
- Push prov=3, mispred=1 -> o_wr_en=4'b1000, o_wr_alloc=0, o_alloc_cnt unchanged; push prov=0, mispred=0 -> o_wr_en=4'b0001.
- During INIT push 5 back-to-back requests -> first 4 accepted, o_upd_ready=0 thereafter; after o_init_done they drain in order on 4 consecutive cycles, then ready=1.
- In RUN with 2 queued entries, pulse i_clear -> no update writes; 8 sweep cycles with o_init_done=0; FIFO empty on return to RUN.
- CNT_W=2: 4 allocating mispredicts -> o_alloc_cnt sequence 1,2,3,3; assert i_rst_n low mid-sweep at idx 4 -> outputs 0, sweep restarts at idx 0.

Source files
------------

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - branch-predictor table update scheduler with zeroing sweep
module bp_update_sched #(
  parameter int IDX_W = 11,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_upd_valid,
  output logic               o_upd_ready,
  input  logic [4*IDX_W-1:0] i_upd_idx,
  input  logic [1:0]         i_upd_prov,
  input  logic               i_upd_taken,
  input  logic               i_upd_mispred,
  input  logic               i_clear,
  output logic [3:0]         o_wr_en,
  output logic [4*IDX_W-1:0] o_wr_idx,
  output logic               o_wr_zero,
  output logic [3:0]         o_wr_alloc,
  output logic               o_wr_taken,
  output logic               o_init_done,
  output logic [CNT_W-1:0]   o_alloc_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 4*IDX_W + 4;

  typedef enum logic [1:0] {S_INIT, S_RUN, S_CLEAR} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [AW:0]        count_q;
  logic [CNT_W-1:0]   alloc_cnt_q;

  logic               sweeping, full, empty, push, pop, flush, do_alloc;
  logic [EW-1:0]      head;
  logic [4*IDX_W-1:0] head_idx;
  logic [1:0]         head_prov, alloc_tbl;
  logic               head_taken, head_mispred;

  assign sweeping     = (state_q != S_RUN);
  assign full         = (count_q == (AW+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign push         = i_upd_valid && !full;
  assign flush        = (state_q == S_RUN) && i_clear;
  // A clear in RUN discards the queue, so the head is not written that cycle either.
  assign pop          = (state_q == S_RUN) && !empty && !i_clear;

  assign head         = mem[rptr_q];
  assign head_idx     = head[4*IDX_W-1:0];
  assign head_prov    = head[4*IDX_W +: 2];
  assign head_taken   = head[4*IDX_W+2];
  assign head_mispred = head[4*IDX_W+3];
  assign alloc_tbl    = head_prov + 2'd1;
  assign do_alloc     = pop && head_mispred && (head_prov != 2'd3);

  assign o_upd_ready  = !full;
  assign o_init_done  = (state_q == S_RUN);
  assign o_alloc_cnt  = alloc_cnt_q;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    case (state_q)
      S_RUN: begin
        if (i_clear) begin
          state_d = S_CLEAR;
          sweep_d = '0;
        end
      end
      default: begin
        if (i_clear) begin
          sweep_d = '0;
        end else if (sweep_q == '1) begin
          state_d = S_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
        end
      end
    endcase
  end

  // Write strobes are masked while reset is held so the arrays see no sweep writes.
  always_comb begin
    o_wr_en    = '0;
    o_wr_idx   = '0;
    o_wr_zero  = 1'b0;
    o_wr_alloc = '0;
    o_wr_taken = 1'b0;
    if (i_rst_n) begin
      if (sweeping) begin
        o_wr_en   = 4'hF;
        o_wr_zero = 1'b1;
        o_wr_idx  = {4{sweep_q}};
      end else begin
        o_wr_idx = head_idx;
        if (pop) begin
          o_wr_en[head_prov] = 1'b1;
          o_wr_taken         = head_taken;
          if (do_alloc) begin
            o_wr_en[alloc_tbl]    = 1'b1;
            o_wr_alloc[alloc_tbl] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      alloc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      if (flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + 1'b1;
        if (pop)  rptr_q <= rptr_q + 1'b1;
        if (push && !pop)      count_q <= count_q + 1'b1;
        else if (!push && pop) count_q <= count_q - 1'b1;
      end
      if (do_alloc && (alloc_cnt_q != '1)) alloc_cnt_q <= alloc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr_q] <= {i_upd_mispred, i_upd_taken, i_upd_prov, i_upd_idx};
  end

endmodule
